// File: rtl/ntt_result_streamer_if.sv
// Signal bundle between the result streamer, the multiplier's read port and
// the downstream consumer.
//
// Output stream handshake: a beat transfers on a rising clock edge where
// out_valid and out_ready are both 1. Once out_valid is raised, out_data,
// out_index and out_last hold steady until that beat transfers. out_valid
// never depends on out_ready.
interface ntt_result_streamer_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                  ntt_done;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;
   logic                  busy;
   logic                  stream_done;
   // observability: FSM state and credits in use (in-flight reads + FIFO fill)
   logic [1:0]            dbg_state;
   logic [7:0]            dbg_credit;

   modport master (
      input  ntt_done,
      output rd_addr,
      input  rd_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_index,
      output out_last,
      output busy,
      output stream_done,
      output dbg_state,
      output dbg_credit
   );

   modport slave (
      output ntt_done,
      input  rd_addr,
      output rd_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_index,
      input  out_last,
      input  busy,
      input  stream_done,
      input  dbg_state,
      input  dbg_credit
   );
endinterface

// File: rtl/ntt_result_streamer.sv
// Reads the N result coefficients out of the NTT multiplier once it reports
// completion and re-emits them as an in-order valid/ready stream. A small
// credit-managed FIFO soaks up read latency and downstream stalls so that the
// stream runs at one coefficient per cycle when the consumer never stalls.
module ntt_result_streamer #(
   parameter int          N            = 4096,
   parameter int          WIDTH        = 32,
   parameter int unsigned Q            = 8380417,
   parameter int          ADDR_WIDTH   = 12,
   parameter int          READ_LATENCY = 1,
   parameter int          CENTERED     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ntt_result_streamer_if.master bus
);

   // One slot per read that can be outstanding plus two, so the issue side
   // never waits on the pop side when the consumer keeps up.
   localparam int FIFO_DEPTH = READ_LATENCY + 2;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int FL_W       = $clog2(READ_LATENCY + 2);
   localparam int CR_W       = CNT_W + FL_W;
   localparam int IDX_W      = ADDR_WIDTH + 1;

   localparam logic [IDX_W-1:0]      N_IDX     = IDX_W'(N);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
   localparam logic [CR_W-1:0]       DEPTH_CR  = CR_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]      PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [WIDTH-1:0]      Q_W       = WIDTH'(Q);
   localparam logic [WIDTH-1:0]      HALF_W    = WIDTH'((Q - 1) / 2);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   // control state
   logic [1:0]            state_q, state_d;
   logic                  done_q;
   logic [IDX_W-1:0]      issue_idx_q, issue_idx_d;
   logic [IDX_W-1:0]      accept_idx_q, accept_idx_d;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic [FL_W-1:0]       in_flight_q, in_flight_d;

   // FIFO state
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic [WIDTH-1:0]      mem_data_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_idx_q  [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_last_q;

   // per-cycle events
   logic                  trigger;
   logic                  issue;
   logic                  pop;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [WIDTH-1:0]      wr_data;
   logic [CR_W-1:0]       credit_used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_MAX) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // A new stream starts only on a rising edge of the done level.
   assign trigger     = bus.ntt_done & ~done_q;
   assign credit_used = CR_W'(in_flight_q) + CR_W'(fifo_cnt_q);
   // Every issued read already owns a FIFO slot, so the FIFO cannot overflow.
   assign issue       = (state_q == S_ISSUE) && (issue_idx_q < N_IDX) &&
                        (credit_used < DEPTH_CR);
   assign pop         = bus.out_valid & bus.out_ready;

   // Read-return tracking: an issue tag (valid + index) travels alongside the
   // read and marks the cycle its data is on rd_data.
   generate
      if (READ_LATENCY == 0) begin : g_comb_read
         assign wr_en  = issue;
         assign wr_idx = issue_idx_q[ADDR_WIDTH-1:0];
      end else begin : g_pipe_read
         logic [READ_LATENCY-1:0] tag_v_q;
         logic [ADDR_WIDTH-1:0]   tag_idx_q [READ_LATENCY];

         // Shift issue tags by one stage per cycle; reset drops them all.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               tag_v_q <= '0;
               for (int i = 0; i < READ_LATENCY; i++) begin
                  tag_idx_q[i] <= '0;
               end
            end else begin
               tag_v_q[0]   <= issue;
               tag_idx_q[0] <= issue_idx_q[ADDR_WIDTH-1:0];
               for (int i = 1; i < READ_LATENCY; i++) begin
                  tag_v_q[i]   <= tag_v_q[i-1];
                  tag_idx_q[i] <= tag_idx_q[i-1];
               end
            end
         end

         assign wr_en  = tag_v_q[READ_LATENCY-1];
         assign wr_idx = tag_idx_q[READ_LATENCY-1];
      end
   endgenerate

   // Convert the returning coefficient on its way into the FIFO.
   always_comb begin
      wr_data = bus.rd_data;
      if ((CENTERED != 0) && (bus.rd_data > HALF_W)) begin
         wr_data = bus.rd_data - Q_W;
      end
   end

   // In-flight read count: up on issue, down when the tag retires.
   always_comb begin
      in_flight_d = in_flight_q + FL_W'(issue) - FL_W'(wr_en);
   end

   // FIFO pointer and occupancy bookkeeping; write and pop may coincide.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({wr_en, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Stream sequencing: wait for trigger, issue all reads, drain, pulse done.
   always_comb begin
      state_d      = state_q;
      issue_idx_d  = issue_idx_q;
      accept_idx_d = accept_idx_q;
      if (pop) begin
         accept_idx_d = accept_idx_q + IDX_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d      = S_ISSUE;
               issue_idx_d  = '0;
               accept_idx_d = '0;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               issue_idx_d = issue_idx_q + IDX_W'(1);
               if (issue_idx_q == LAST_IDX) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && (accept_idx_q == LAST_IDX) && (in_flight_q == '0) &&
                (fifo_cnt_q == CNT_W'(1)) && !wr_en) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers, including the held copy of the last issued address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         done_q       <= 1'b0;
         issue_idx_q  <= '0;
         accept_idx_q <= '0;
         last_addr_q  <= '0;
         in_flight_q  <= '0;
      end else begin
         state_q      <= state_d;
         done_q       <= bus.ntt_done;
         issue_idx_q  <= issue_idx_d;
         accept_idx_q <= accept_idx_d;
         in_flight_q  <= in_flight_d;
         if (issue) begin
            last_addr_q <= issue_idx_q[ADDR_WIDTH-1:0];
         end
      end
   end

   // FIFO storage: each entry carries converted data, its index and last flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         mem_last_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_idx_q[i]  <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         if (wr_en) begin
            mem_data_q[wr_ptr_q] <= wr_data;
            mem_idx_q[wr_ptr_q]  <= wr_idx;
            mem_last_q[wr_ptr_q] <= (wr_idx == LAST_ADDR);
         end
      end
   end

   // The read address follows issue_idx on issue cycles and holds otherwise.
   assign bus.rd_addr     = issue ? issue_idx_q[ADDR_WIDTH-1:0] : last_addr_q;

   assign bus.out_valid   = (fifo_cnt_q != '0);
   assign bus.out_data    = mem_data_q[rd_ptr_q];
   assign bus.out_index   = mem_idx_q[rd_ptr_q];
   assign bus.out_last    = mem_last_q[rd_ptr_q];
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.stream_done = (state_q == S_FINISH);

   assign bus.dbg_state   = state_q;
   assign bus.dbg_credit  = 8'(credit_used);

endmodule
